// File: rtl/data_memory_unit.sv
// Word-organised data RAM behind the MEM stage, with a registered read port and an end-of-program memory dump.
// Optional build macro DMEM_DUMP_SKIP_ZERO_EN: suppresses the dump-valid strobe for all-zero words.
module data_memory_unit #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_memoryWrite,
  input  logic        i_readOrWrite,
  input  logic [31:0] i_memAddress,
  input  logic [31:0] i_memData,
  output logic [31:0] o_readData,
  output logic        o_readValid,
  output logic        o_busy,
  output logic        o_dumpValid,
  output logic [31:0] o_dumpAddr,
  output logic [31:0] o_dumpData,
  output logic        o_halted
);

  typedef enum logic [1:0] {IDLE = 2'd0, DUMP = 2'd1, HALT = 2'd2} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t        r_state;
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_k;
  logic [31:0]   r_readData;
  logic          r_readValid;
  logic          r_busy;
  logic          r_dumpValid;
  logic [31:0]   r_dumpAddr;
  logic [31:0]   r_dumpData;
  logic          r_halted;

  logic [AW-1:0] w_idx;
  logic          w_in_range;
  logic          w_sentinel;
  logic          w_store;
  logic          w_load;
  logic [31:0]   w_dump_word;
  logic          w_dump_show;

  assign w_idx      = i_memAddress[AW+1:2];
  assign w_in_range = (i_memAddress[31:AW+2] == {(30-AW){1'b0}});
  assign w_sentinel = i_readOrWrite & ~i_memoryWrite & (i_memAddress == 32'hFFFF_FFFF);
  // Writes are gated by reset so a store presented while reset is held never lands.
  assign w_store    = reset & (r_state == IDLE) & i_readOrWrite & i_memoryWrite & w_in_range;
  assign w_load     = (r_state == IDLE) & i_readOrWrite & ~i_memoryWrite & ~w_sentinel;

  // Select the word being dumped and decide whether it is presented.
  always_comb begin
    w_dump_word = r_mem[r_k];
`ifdef DMEM_DUMP_SKIP_ZERO_EN
    w_dump_show = (w_dump_word != 32'h0000_0000);
`else
    w_dump_show = 1'b1;
`endif
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_mem[w_idx] <= i_memData;
    end
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_k         <= {AW{1'b0}};
      r_readData  <= 32'h0000_0000;
      r_readValid <= 1'b0;
      r_busy      <= 1'b0;
      r_dumpValid <= 1'b0;
      r_dumpAddr  <= 32'h0000_0000;
      r_dumpData  <= 32'h0000_0000;
      r_halted    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_dumpValid <= 1'b0;
          r_dumpAddr  <= 32'h0000_0000;
          r_dumpData  <= 32'h0000_0000;
          r_halted    <= 1'b0;
          if (w_sentinel) begin
            r_state     <= DUMP;
            r_k         <= {AW{1'b0}};
            r_busy      <= 1'b1;
            r_readValid <= 1'b0;
          end else if (w_load) begin
            r_busy      <= 1'b0;
            r_readValid <= 1'b1;
            r_readData  <= w_in_range ? r_mem[w_idx] : 32'h0000_0000;
          end else begin
            r_busy      <= 1'b0;
            r_readValid <= 1'b0;
          end
        end
        DUMP: begin
          r_busy      <= 1'b1;
          r_readValid <= 1'b0;
          r_halted    <= 1'b0;
          r_dumpValid <= w_dump_show;
          r_dumpAddr  <= w_dump_show ? {{(30-AW){1'b0}}, r_k, 2'b00} : 32'h0000_0000;
          r_dumpData  <= w_dump_show ? w_dump_word : 32'h0000_0000;
          r_k         <= r_k + AW'(1);
          if (r_k == LAST_IDX) begin
            r_state <= HALT;
          end else begin
            r_state <= DUMP;
          end
        end
        HALT: begin
          r_busy      <= 1'b1;
          r_halted    <= 1'b1;
          r_readValid <= 1'b0;
          r_dumpValid <= 1'b0;
          r_dumpAddr  <= 32'h0000_0000;
          r_dumpData  <= 32'h0000_0000;
        end
        default: begin
          r_state     <= IDLE;
          r_k         <= {AW{1'b0}};
          r_busy      <= 1'b0;
          r_readValid <= 1'b0;
          r_dumpValid <= 1'b0;
          r_dumpAddr  <= 32'h0000_0000;
          r_dumpData  <= 32'h0000_0000;
          r_halted    <= 1'b0;
        end
      endcase
    end
  end

  assign o_readData  = r_readData;
  assign o_readValid = r_readValid;
  assign o_busy      = r_busy;
  assign o_dumpValid = r_dumpValid;
  assign o_dumpAddr  = r_dumpAddr;
  assign o_dumpData  = r_dumpData;
  assign o_halted    = r_halted;

endmodule

// File: tb/tb_data_memory_unit.sv
// Self-checking bench for data_memory_unit: table-driven load/store vectors plus dump, halt and reset sequences.
module tb_data_memory_unit;
  localparam int DEPTH = 512;
  localparam int AW    = 9;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_memoryWrite = 1'b0;
  logic        i_readOrWrite = 1'b0;
  logic [31:0] i_memAddress = 32'h0;
  logic [31:0] i_memData = 32'h0;
  logic [31:0] o_readData;
  logic        o_readValid;
  logic        o_busy;
  logic        o_dumpValid;
  logic [31:0] o_dumpAddr;
  logic [31:0] o_dumpData;
  logic        o_halted;

  int tests = 0;
  int fails = 0;
  logic [31:0] model [DEPTH];

  typedef struct {
    logic        wr;
    logic        acc;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_v;
    logic [31:0] exp_d;
  } vec_t;

  typedef struct {
    logic        v;
    logic [31:0] d;
  } rsp_t;

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic [31:0] d;
    logic        halted;
  } dump_t;

  vec_t  vecs [16];
  rsp_t  rsp_q [$];
  dump_t dump_q [$];

  data_memory_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .i_memoryWrite(i_memoryWrite), .i_readOrWrite(i_readOrWrite),
    .i_memAddress(i_memAddress), .i_memData(i_memData),
    .o_readData(o_readData), .o_readValid(o_readValid), .o_busy(o_busy),
    .o_dumpValid(o_dumpValid), .o_dumpAddr(o_dumpAddr), .o_dumpData(o_dumpData),
    .o_halted(o_halted)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic acc, input logic [31:0] a, input logic [31:0] d);
    i_memoryWrite = wr;
    i_readOrWrite = acc;
    i_memAddress  = a;
    i_memData     = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rdata"}, o_readData, 32'h0);
    chk({tag, "_rvalid"}, {31'h0, o_readValid}, 32'h0);
    chk({tag, "_busy"}, {31'h0, o_busy}, 32'h0);
    chk({tag, "_dvalid"}, {31'h0, o_dumpValid}, 32'h0);
    chk({tag, "_daddr"}, o_dumpAddr, 32'h0);
    chk({tag, "_ddata"}, o_dumpData, 32'h0);
    chk({tag, "_halted"}, {31'h0, o_halted}, 32'h0);
  endtask

  task automatic do_load(input string name, input logic [31:0] a, input logic [31:0] exp);
    rsp_t r;
    drive(1'b0, 1'b1, a, 32'h0);
    rsp_q.push_back('{1'b1, exp});
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    r = rsp_q.pop_front();
    chk({name, "_valid"}, {31'h0, o_readValid}, {31'h0, r.v});
    chk({name, "_data"}, o_readData, r.d);
    chk({name, "_busy"}, {31'h0, o_busy}, 32'h0);
  endtask

  // Runs a dump from the sentinel; abort_at >= 0 asserts reset once that word is on the port.
  task automatic run_dump(input int abort_at);
    dump_t e;
    int    pulses = 0;
    int    first  = -1;
    int    last   = -1;
    int    k;
    logic  v;
    drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0);
    tick();
    chk("sentinel_busy", {31'h0, o_busy}, 32'h1);
    chk("sentinel_rvalid", {31'h0, o_readValid}, 32'h0);
    chk("sentinel_dvalid", {31'h0, o_dumpValid}, 32'h0);
    for (int c = 1; c <= DEPTH + 1; c++) begin
      if (c % 2 == 1) drive(1'b1, 1'b1, 32'h14, $urandom);
      else            drive(1'b0, 1'b1, 32'h0, 32'h0);
      if (c <= DEPTH) begin
        k = c - 1;
`ifdef DMEM_DUMP_SKIP_ZERO_EN
        v = (model[k] != 32'h0);
`else
        v = 1'b1;
`endif
        dump_q.push_back('{v, v ? (32'(k) << 2) : 32'h0, v ? model[k] : 32'h0, 1'b0});
      end else begin
        dump_q.push_back('{1'b0, 32'h0, 32'h0, 1'b1});
      end
      tick();
      e = dump_q.pop_front();
      chk("dump_valid", {31'h0, o_dumpValid}, {31'h0, e.v});
      chk("dump_addr", o_dumpAddr, e.a);
      chk("dump_data", o_dumpData, e.d);
      chk("dump_halted", {31'h0, o_halted}, {31'h0, e.halted});
      chk("dump_busy", {31'h0, o_busy}, 32'h1);
      chk("dump_rvalid", {31'h0, o_readValid}, 32'h0);
      if (o_dumpValid) begin
        pulses++;
        if (first < 0) first = c;
        last = c;
      end
      if (abort_at >= 0 && c == abort_at + 1) begin
        reset = 1'b0;
        #1;
        chk_zero("abort");
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        dump_q.delete();
        break;
      end
    end
    if (abort_at < 0) begin
`ifdef DMEM_DUMP_SKIP_ZERO_EN
      chk("dump_pulses", 32'(pulses), 32'd2);
`else
      chk("dump_pulses", 32'(pulses), 32'(DEPTH));
`endif
      chk("dump_first_cycle", 32'(first), 32'd1);
      chk("dump_last_cycle", 32'(last), 32'(DEPTH));
    end
  endtask

  initial begin
    rsp_t r;
    vecs[0]  = '{1'b1, 1'b1, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0012, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 1'b1, 32'h0000_1000, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001};
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_07FC, 32'h0000_0002, 1'b0, 32'h0000_0001};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_07FF, 32'h0000_0000, 1'b1, 32'h0000_0002};
    vecs[9]  = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0055, 1'b0, 32'h0000_0002};
    vecs[10] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'h0000_0002};
    vecs[11] = '{1'b1, 1'b1, 32'h0000_0020, 32'h1111_1111, 1'b0, 32'h0000_0002};
    vecs[12] = '{1'b0, 1'b1, 32'h0000_0800, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[13] = '{1'b0, 1'b1, 32'h0000_0020, 32'h0000_0000, 1'b1, 32'h1111_1111};
    vecs[14] = '{1'b1, 1'b1, 32'h0000_0024, 32'hA5A5_0000, 1'b0, 32'h1111_1111};
    vecs[15] = '{1'b0, 1'b1, 32'h0000_0024, 32'h0000_0000, 1'b1, 32'hA5A5_0000};

    repeat (3) @(posedge clk);
    #1;
    chk_zero("in_reset");
    reset = 1'b1;
    tick();
    chk_zero("after_reset");

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].wr, vecs[i].acc, vecs[i].addr, vecs[i].data);
      rsp_q.push_back('{vecs[i].exp_v, vecs[i].exp_d});
      tick();
      r = rsp_q.pop_front();
      chk($sformatf("vec%0d_valid", i), {31'h0, o_readValid}, {31'h0, r.v});
      chk($sformatf("vec%0d_data", i), o_readData, r.d);
      chk($sformatf("vec%0d_busy", i), {31'h0, o_busy}, 32'h0);
      chk($sformatf("vec%0d_dvalid", i), {31'h0, o_dumpValid}, 32'h0);
    end

    drive(1'b1, 1'b1, 32'h0000_0020, 32'h0000_0BAD);
    reset = 1'b0;
    #1;
    chk_zero("store_in_reset_async");
    repeat (3) tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    tick();
    chk_zero("store_in_reset_release");
    do_load("reset_store_dropped", 32'h0000_0020, 32'h1111_1111);

    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b1, 32'(i) << 2, 32'h0);
      model[i] = 32'h0;
      tick();
    end
    drive(1'b1, 1'b1, 32'h0000_0000, 32'h0000_0001);
    model[0] = 32'h0000_0001;
    tick();
    drive(1'b1, 1'b1, 32'h0000_07FC, 32'h0000_0002);
    model[DEPTH-1] = 32'h0000_0002;
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("pre_dump_busy", {31'h0, o_busy}, 32'h0);

    run_dump(-1);
    drive(1'b1, 1'b1, 32'h0000_0000, 32'h0000_0099);
    tick();
    drive(1'b0, 1'b1, 32'h0000_0000, 32'h0);
    tick();
    chk("halt_halted", {31'h0, o_halted}, 32'h1);
    chk("halt_busy", {31'h0, o_busy}, 32'h1);
    chk("halt_dvalid", {31'h0, o_dumpValid}, 32'h0);
    chk("halt_rvalid", {31'h0, o_readValid}, 32'h0);

    drive(1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    #1;
    chk_zero("halt_reset");
    tick();
    reset = 1'b1;
    tick();
    do_load("halt_store_ignored", 32'h0000_0000, 32'h0000_0001);
    do_load("dump_store_ignored", 32'h0000_0014, 32'h0000_0000);

    run_dump(100);
    tick();
    chk("abort_idle_busy", {31'h0, o_busy}, 32'h0);
    chk("abort_idle_halted", {31'h0, o_halted}, 32'h0);
    do_load("abort_ram_kept", 32'h0000_0000, 32'h0000_0001);
    do_load("abort_ram_last", 32'h0000_07FC, 32'h0000_0002);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
